// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: stage-latch
// controls, PC write enable, EX operand forward selects and stall/flush counters.
module hazard_ctrl_unit #(
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rs_ex,
    input  logic [4:0]       rt_ex,
    input  logic [4:0]       wsel_ex,
    input  logic             wen_ex,
    input  logic             mren_ex,
    input  logic [4:0]       wsel_mem,
    input  logic             wen_mem,
    input  logic [4:0]       wsel_wb,
    input  logic             wen_wb,
    input  logic             br_taken,
    input  logic             jump,
    output logic             PC_WEN,
    output logic [1:0]       fd_state,
    output logic [1:0]       de_state,
    output logic [1:0]       em_state,
    output logic [1:0]       mw_state,
    output logic [1:0]       fsel_a,
    output logic [1:0]       fsel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_LU   = 2'd1;
    localparam logic [1:0] ST_BR   = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [1:0] L_RUN   = 2'b00;
    localparam logic [1:0] L_STALL = 2'b01;
    localparam logic [1:0] L_FLUSH = 2'b10;

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_INIT = 3'(BR_PENALTY - 1);

    logic [1:0] state, state_nxt;
    logic [2:0] step, step_nxt;
    logic       memwait, load_use, raw_unc;
    logic       flush_evt, stall_evt;

    // Nearest enabled producer within the forwarding depth; $0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] w1, input logic e1,
                                           input logic [4:0] w2, input logic e2,
                                           input logic [4:0] w3, input logic e3);
        if (src == 5'd0)                           return 2'd0;
        if (e1 && w1 == src)                       return 2'd1;
        if (FWD_DEPTH >= 2 && e2 && w2 == src)     return 2'd2;
        if (FWD_DEPTH >= 3 && e3 && w3 == src)     return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic id_match(input logic [4:0] w, input logic e,
                                      input logic [4:0] rs, input logic [4:0] rt);
        return e && (w != 5'd0) && (w == rs || w == rt);
    endfunction

    assign memwait  = ((dREN | dWEN) & ~dhit) | ~ihit;
    assign load_use = mren_ex & id_match(wsel_ex, wen_ex, rs_id, rt_id);
    assign raw_unc  = (FWD_DEPTH < 2 && id_match(wsel_mem, wen_mem, rs_id, rt_id)) ||
                      (FWD_DEPTH < 3 && id_match(wsel_wb, wen_wb, rs_id, rt_id));

    always_comb begin
        PC_WEN    = 1'b1;
        fd_state  = L_RUN;
        de_state  = L_RUN;
        em_state  = L_RUN;
        mw_state  = L_RUN;
        fsel_a    = fwd_sel(rs_ex, wsel_ex, wen_ex, wsel_mem, wen_mem, wsel_wb, wen_wb);
        fsel_b    = fwd_sel(rt_ex, wsel_ex, wen_ex, wsel_mem, wen_mem, wsel_wb, wen_wb);
        state_nxt = state;
        step_nxt  = step;
        flush_evt = 1'b0;
        if (!nRST) begin
            PC_WEN   = 1'b0;
            fd_state = L_FLUSH;
            de_state = L_FLUSH;
            em_state = L_FLUSH;
            mw_state = L_FLUSH;
            fsel_a   = 2'd0;
            fsel_b   = 2'd0;
        end else if (state == ST_HALT) begin
            PC_WEN   = 1'b0;
            fd_state = L_FLUSH;
            de_state = L_FLUSH;
        end else if (memwait) begin
            PC_WEN   = 1'b0;
            fd_state = L_STALL;
            de_state = L_STALL;
            em_state = L_STALL;
            mw_state = L_STALL;
        end else begin
            if (br_taken) begin
                fd_state  = L_FLUSH;
                de_state  = L_FLUSH;
                flush_evt = 1'b1;
                state_nxt = (BR_PENALTY > 1) ? ST_BR : ST_RUN;
                step_nxt  = (BR_PENALTY > 1) ? BR_INIT : 3'd0;
            end else if (state == ST_BR) begin
                fd_state  = L_FLUSH;
                step_nxt  = step - 3'd1;
                if (step <= 3'd1) state_nxt = ST_RUN;
            end else if (load_use || state == ST_LU) begin
                PC_WEN   = 1'b0;
                fd_state = L_STALL;
                de_state = L_FLUSH;
                if (state == ST_LU) begin
                    step_nxt = step - 3'd1;
                    if (step <= 3'd1) state_nxt = ST_RUN;
                end else if (LOAD_LAT > 1) begin
                    state_nxt = ST_LU;
                    step_nxt  = LU_INIT;
                end
            end else if (raw_unc) begin
                PC_WEN   = 1'b0;
                fd_state = L_STALL;
                de_state = L_FLUSH;
            end else if (jump && state == ST_RUN) begin
                fd_state  = L_FLUSH;
                flush_evt = 1'b1;
            end
            if (halt) state_nxt = ST_HALT;
        end
    end

    assign stall_evt = !PC_WEN && (state != ST_HALT);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= ST_RUN;
            step      <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            if (stall_evt) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (FWD_DEPTH 1..3, LOAD_LAT 3,
// BR_PENALTY 2) share one stimulus stream and are checked against hand-computed values.
module tb_hazard_ctrl_unit;

    localparam int F_PC = 0, F_FD = 1, F_DE = 2, F_EM = 3, F_MW = 4;
    localparam int F_FA = 5, F_FB = 6, F_SC = 7, F_FC = 8;

    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, dREN, dWEN, halt;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wsel_ex, wsel_mem, wsel_wb;
    logic       wen_ex, mren_ex, wen_mem, wen_wb, br_taken, jump;

    logic        pc_wen  [1:3];
    logic [1:0]  fd_st   [1:3];
    logic [1:0]  de_st   [1:3];
    logic [1:0]  em_st   [1:3];
    logic [1:0]  mw_st   [1:3];
    logic [1:0]  fsa     [1:3];
    logic [1:0]  fsb     [1:3];
    logic [31:0] stall_c [1:3];
    logic [31:0] flush_c [1:3];

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        hazard_ctrl_unit #(.FWD_DEPTH(g), .LOAD_LAT(3), .BR_PENALTY(2), .CNT_W(32)) u_dut (
            .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
            .halt(halt), .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
            .wsel_ex(wsel_ex), .wen_ex(wen_ex), .mren_ex(mren_ex),
            .wsel_mem(wsel_mem), .wen_mem(wen_mem), .wsel_wb(wsel_wb), .wen_wb(wen_wb),
            .br_taken(br_taken), .jump(jump), .PC_WEN(pc_wen[g]),
            .fd_state(fd_st[g]), .de_state(de_st[g]), .em_state(em_st[g]), .mw_state(mw_st[g]),
            .fsel_a(fsa[g]), .fsel_b(fsb[g]), .stall_cnt(stall_c[g]), .flush_cnt(flush_c[g])
        );
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int g, input int f);
        case (f)
            F_PC:    return 32'(pc_wen[g]);
            F_FD:    return 32'(fd_st[g]);
            F_DE:    return 32'(de_st[g]);
            F_EM:    return 32'(em_st[g]);
            F_MW:    return 32'(mw_st[g]);
            F_FA:    return 32'(fsa[g]);
            F_FB:    return 32'(fsb[g]);
            F_SC:    return stall_c[g];
            default: return flush_c[g];
        endcase
    endfunction

    task automatic expect3(input string tag, input int f,
                           input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        check_vec($sformatf("%s[d1]", tag), obs(1, f), e1);
        check_vec($sformatf("%s[d2]", tag), obs(2, f), e2);
        check_vec($sformatf("%s[d3]", tag), obs(3, f), e3);
    endtask

    task automatic expect_all(input string tag, input int f, input logic [31:0] e);
        expect3(tag, f, e, e, e);
    endtask

    task automatic expect_lat(input string tag, input logic [31:0] pc, input logic [31:0] fd,
                              input logic [31:0] de, input logic [31:0] em, input logic [31:0] mw);
        expect_all({tag, ".pc"}, F_PC, pc);
        expect_all({tag, ".fd"}, F_FD, fd);
        expect_all({tag, ".de"}, F_DE, de);
        expect_all({tag, ".em"}, F_EM, em);
        expect_all({tag, ".mw"}, F_MW, mw);
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
        rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0;
        wsel_ex = '0; wen_ex = 1'b0; mren_ex = 1'b0;
        wsel_mem = '0; wen_mem = 1'b0; wsel_wb = '0; wen_wb = 1'b0;
        br_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        nRST = 1'b0; wsel_ex = 5'd3; wen_ex = 1'b1; rs_ex = 5'd3;
        step(); step();
        expect_lat("rst", 0, 2, 2, 2, 2);
        expect_all("rst.fsel_a", F_FA, 0);
        expect_all("rst.stall", F_SC, 0);
        expect_all("rst.flush", F_FC, 0);
        nRST = 1'b1; #1;
        expect_all("post_rst.fsel_a", F_FA, 1);
        expect_all("post_rst.pc", F_PC, 1);
        idle(); step();

        // load-use, three stall cycles
        wsel_ex = 5'd5; wen_ex = 1'b1; mren_ex = 1'b1; rs_id = 5'd5; #1;
        expect_lat("lu0", 0, 1, 2, 0, 0);
        step(); idle(); #1;
        expect_lat("lu1", 0, 1, 2, 0, 0);
        step(); #1;
        expect_lat("lu2", 0, 1, 2, 0, 0);
        step(); #1;
        expect_lat("lu_done", 1, 0, 0, 0, 0);
        expect_all("lu.stall", F_SC, 3);

        // forwarding priority and depth
        wsel_ex = 5'd3; wen_ex = 1'b1; wsel_mem = 5'd3; wen_mem = 1'b1; rs_ex = 5'd3; #1;
        expect_all("fwd_near", F_FA, 1);
        wsel_ex = 5'd0; wsel_mem = 5'd0; #1;
        expect_all("fwd_r0", F_FA, 0);
        wsel_mem = 5'd3; wen_ex = 1'b0; #1;
        expect3("fwd_mem", F_FA, 0, 2, 2);
        wsel_wb = 5'd9; wen_wb = 1'b1; rt_ex = 5'd9; #1;
        expect3("fwd_wb", F_FB, 0, 0, 3);
        idle(); #1;

        // taken branch, two-cycle penalty
        br_taken = 1'b1; #1;
        expect_lat("br0", 1, 2, 2, 0, 0);
        step(); br_taken = 1'b0; #1;
        expect_lat("br1", 1, 2, 0, 0, 0);
        step(); #1;
        expect_lat("br2", 1, 0, 0, 0, 0);
        expect_all("br.flush", F_FC, 1);

        // data wait freezes BR_FLUSH
        br_taken = 1'b1; step(); br_taken = 1'b0; dREN = 1'b1; dhit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1; expect_lat($sformatf("mw%0d", k), 0, 1, 1, 1, 1);
            step();
        end
        dhit = 1'b1; #1;
        expect_lat("br_resume", 1, 2, 0, 0, 0);
        step(); idle(); #1;
        expect_lat("br_resume_done", 1, 0, 0, 0, 0);
        expect_all("mw.flush", F_FC, 2);
        expect_all("mw.stall", F_SC, 7);

        // uncovered RAW versus forwarding depth
        wsel_wb = 5'd7; wen_wb = 1'b1; rs_id = 5'd7; rs_ex = 5'd7; #1;
        expect3("raw_wb.pc", F_PC, 0, 0, 1);
        expect3("raw_wb.de", F_DE, 2, 2, 0);
        expect3("raw_wb.fsel", F_FA, 0, 0, 3);
        step(); idle(); #1;
        expect_all("raw_wb_done.pc", F_PC, 1);
        wsel_mem = 5'd7; wen_mem = 1'b1; rt_id = 5'd7; #1;
        expect3("raw_mem.pc", F_PC, 0, 1, 1);
        step(); idle(); #1;
        expect3("raw.stall", F_SC, 9, 8, 7);

        // fetch miss
        ihit = 1'b0; #1;
        expect_lat("imiss", 0, 1, 1, 1, 1);
        step(); ihit = 1'b1; #1;
        expect3("imiss.stall", F_SC, 10, 9, 8);

        // jump
        jump = 1'b1; #1;
        expect_lat("jmp", 1, 2, 0, 0, 0);
        step(); jump = 1'b0; #1;
        expect_all("jmp.flush", F_FC, 3);

        // branch overrides a load-use
        mren_ex = 1'b1; wen_ex = 1'b1; wsel_ex = 5'd4; rt_id = 5'd4; br_taken = 1'b1; #1;
        expect_lat("br_lu0", 1, 2, 2, 0, 0);
        step(); idle(); #1;
        expect_lat("br_lu1", 1, 2, 0, 0, 0);
        step(); #1;
        expect_all("br_lu.flush", F_FC, 4);
        expect3("br_lu.stall", F_SC, 10, 9, 8);

        // halt is not taken while memory waits
        halt = 1'b1; dREN = 1'b1; dhit = 1'b0; #1;
        expect_all("halt_wait.pc", F_PC, 0);
        step(); halt = 1'b0; dREN = 1'b0; #1;
        expect_lat("halt_blocked", 1, 0, 0, 0, 0);
        expect3("halt_wait.stall", F_SC, 11, 10, 9);

        // sticky halt, then reset
        halt = 1'b1; #1;
        expect_all("halt_in.pc", F_PC, 1);
        step(); halt = 1'b0; br_taken = 1'b1; #1;
        expect_lat("halted", 0, 2, 2, 0, 0);
        step(); step(); #1;
        expect_lat("halted2", 0, 2, 2, 0, 0);
        expect3("halted.stall", F_SC, 11, 10, 9);
        expect_all("halted.flush", F_FC, 4);
        nRST = 1'b0; step();
        nRST = 1'b1; br_taken = 1'b0; #1;
        expect_lat("rerun", 1, 0, 0, 0, 0);
        expect_all("rerun.stall", F_SC, 0);
        expect_all("rerun.flush", F_FC, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
